// File: rtl/des_round_engine.sv
// Single-DES Feistel datapath and sequencer: IP, NUM_ROUNDS rounds fed by an external
// subkey source, final swap and FP. One round takes two cycles (key request + round).
//
// state | meaning
// IDLE  | waiting for start, result held on data_out
// KREQ  | key_adv high, key source advancing to the next subkey
// RND   | one Feistel round using kout
// OUT   | final swap + FP into data_out
module des_round_engine #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] data_in,
    input  logic [47:0] kout,
    output logic        key_clear,
    output logic        key_adv,
    output logic        busy,
    output logic [63:0] data_out,
    output logic        out_valid
);

    typedef enum logic [1:0] {IDLE, KREQ, RND, OUT} state_t;

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                 2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    // Indexed by {row, col}: row = outer bits, col = middle four bits of the 6-bit group.
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    // Table entries are 1-based DES bit numbers, DES bit 1 being the MSB.
    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            six = e[47-6*j -: 6];
            s[31-4*j -: 4] = 4'(SBOX[j][{six[5], six[0], six[4:1]}]);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    state_t      state_q;
    logic [31:0] l_q, r_q;
    logic [4:0]  rnd_q;
    logic [63:0] data_out_q;
    logic        out_valid_q, busy_q, key_adv_q;
    logic [31:0] r_d;

    assign r_d = l_q ^ feistel(r_q, kout);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            l_q         <= '0;
            r_q         <= '0;
            rnd_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            key_adv_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            key_adv_q   <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    {l_q, r_q} <= ip_perm(data_in);
                    rnd_q      <= '0;
                    busy_q     <= 1'b1;
                    key_adv_q  <= 1'b1;
                    state_q    <= KREQ;
                end
                KREQ: state_q <= RND;
                RND: begin
                    l_q   <= r_q;
                    r_q   <= r_d;
                    rnd_q <= rnd_q + 5'd1;
                    if (rnd_q == 5'(NUM_ROUNDS - 1)) begin
                        state_q <= OUT;
                    end else begin
                        key_adv_q <= 1'b1;
                        state_q   <= KREQ;
                    end
                end
                OUT: begin
                    data_out_q  <= fp_perm({r_q, l_q});
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The clear strobe must coincide with the accepting start, so it stays combinational.
    assign key_clear = (state_q == IDLE) && start && !rst;
    assign key_adv   = key_adv_q;
    assign busy      = busy_q;
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: acts as the subkey source and scoreboards each result
// against known DES vectors for key 133457799BBCDFF1 and the all-zero key.
module tb_des_round_engine;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [63:0] data_in;
    logic [47:0] kout;
    logic        key_clear, key_adv, busy, out_valid;
    logic [63:0] data_out;

    des_round_engine #(.NUM_ROUNDS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .kout(kout),
        .key_clear(key_clear), .key_adv(key_adv), .busy(busy),
        .data_out(data_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] PT = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT = 64'h85E813540F0AB405;

    logic [47:0]  ks [16];
    logic [47:0]  sched [16];
    logic [63:0]  sb_q [$];
    int           acc_q [$];
    int           n_checks = 0, n_errors = 0;
    int           cyc = 0, idx = 0, adv_cnt = 0, clr_cnt = 0;
    logic         stab_en = 1'b0;
    logic [63:0]  last_out = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Key source: clear rewinds, each adv presents the next scheduled subkey.
    always @(posedge clk) begin
        logic        upd;
        logic [47:0] nk;
        upd = 1'b0;
        nk  = '0;
        cyc++;
        if (key_clear) begin
            idx = 0;
            clr_cnt++;
            acc_q.push_back(cyc);
        end
        if (key_adv) begin
            adv_cnt++;
            nk  = sched[idx % 16];
            idx++;
            upd = 1'b1;
        end
        #1;
        if (upd) kout = nk;
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) check("sb_extra", 64'(sb_q.size()), 64'd1);
            else check("sb_data", data_out, sb_q.pop_front());
            last_out = data_out;
        end else if (stab_en) begin
            check("stable", data_out, last_out);
        end
    end

    task automatic load_sched(input int mode);
        for (int i = 0; i < 16; i++)
            sched[i] = (mode == 0) ? ks[i] : (mode == 1) ? ks[15-i] : 48'h0;
    endtask

    task automatic run_op(input string tag, input logic [63:0] din, input logic [63:0] exp);
        int adv0, clr0, rel;
        bit seen;
        adv0 = adv_cnt;
        clr0 = clr_cnt;
        data_in = din;
        start = 1'b1;
        sb_q.push_back(exp);
        tick();
        start = 1'b0;
        check({tag, "_busy_acc"}, 64'(busy), 64'd1);
        rel = 0;
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            tick();
            rel = n;
            if (n == 32) check({tag, "_busy_k32"}, 64'(busy), 64'd1);
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_latency"}, 64'(rel), 64'd33);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        tick();
        check({tag, "_valid_1cyc"}, 64'(out_valid), 64'd0);
        check({tag, "_adv_cnt"}, 64'(adv_cnt - adv0), 64'd16);
        check({tag, "_clr_cnt"}, 64'(clr_cnt - clr0), 64'd1);
    endtask

    initial begin
        int clr0;
        bit done;
        ks = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
               48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
               48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
               48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        rst = 1'b1; start = 1'b0; data_in = '0; kout = '0;
        load_sched(0);
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_dout", data_out, 64'h0);
        check("rst_adv", 64'(key_adv), 64'd0);
        check("rst_clr", 64'(key_clear), 64'd0);
        tick();

        // Single round visibility, then the rest of the same encryption.
        data_in = PT;
        start = 1'b1;
        sb_q.push_back(CT);
        tick();
        start = 1'b0;
        check("ip_lr", {dut.l_q, dut.r_q}, 64'hCC00CCFF_F0AAF0AA);
        tick();
        tick();
        check("rnd1_lr", {dut.l_q, dut.r_q}, 64'hF0AAF0AA_EF4A6544);
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            tick();
            if (out_valid) done = 1'b1;
        end
        check("enc1_done", 64'(done), 64'd1);
        tick();

        run_op("enc", PT, CT);
        load_sched(1);
        run_op("dec", CT, PT);
        load_sched(2);
        run_op("zero", 64'h0, 64'h8CA64DE9C1B123A7);

        // Reset at k+10 aborts the operation; nothing is pushed for it.
        load_sched(0);
        data_in = PT;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_dout", data_out, 64'h0);
        check("mid_rst_adv", 64'(key_adv), 64'd0);
        last_out = data_out;
        tick();
        run_op("post_rst", PT, CT);

        // Handshake: stray pulses while busy, then continuous start.
        stab_en = 1'b1;
        clr0 = clr_cnt;
        data_in = PT;
        start = 1'b1;
        sb_q.push_back(CT);
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_ignore", 64'(clr_cnt - clr0), 64'd1);
        start = 1'b1;
        repeat (3) sb_q.push_back(CT);
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            tick();
            if (clr_cnt - clr0 >= 4) done = 1'b1;
        end
        start = 1'b0;
        check("hold_accepts", 64'(clr_cnt - clr0), 64'd4);
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            tick();
            if (out_valid) done = 1'b1;
        end
        check("hold_last_done", 64'(done), 64'd1);
        tick();
        stab_en = 1'b0;
        for (int i = acc_q.size() - 3; i < acc_q.size(); i++)
            if (i > 0) check("issue_interval", 64'(acc_q[i] - acc_q[i-1]), 64'd34);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
